// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the time-setting controller.
package clock_set_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_SS = 3'd3,
    LOAD   = 3'd4
  } state_e;

  // Encoding driven on field_sel for the display highlight.
  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HH   = 2'd1,
    FIELD_MM   = 2'd2,
    FIELD_SS   = 2'd3
  } field_e;

  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX = 8'h59;

endpackage

// File: rtl/clock_set_ctrl_bcd_field_inc.sv
// Combinational BCD increment of one time field, wrapping to 00 past max.
// Anything that is not a valid BCD value at or below max also goes to 00,
// so a corrupt snapshot is cleaned up by the first increment.
module bcd_field_inc (
  input  logic [7:0] value,
  input  logic [7:0] max,
  output logic [7:0] next_value
);

  // Valid BCD compares in the same order as its binary image, so >= max works.
  always_comb begin
    next_value = 8'h00;
    if ((value[3:0] > 4'd9) || (value[7:4] > 4'd9) || (value >= max)) begin
      next_value = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      next_value = {value[7:4] + 4'd1, 4'h0};
    end else begin
      next_value = {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-time session controller: snapshots the live time, lets the user step
// each BCD field, then strobes a one-cycle load into the clock counter.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_S    = 30,
  parameter bit          ACTIVE_BLINK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic       blink_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       set_en,
  output logic       set_load,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_S - 1);

  state_e     state_q, state_d;
  logic [7:0] hh_q, mm_q, ss_q;
  logic [7:0] tmo_q;
  logic       blink_q;
  logic       in_set, in_set_d;
  logic       inc_ev, tmo_expire;
  logic [7:0] field_val, field_max, field_next;
  field_e     field_enc;

  bcd_field_inc u_inc (
    .value      (field_val),
    .max        (field_max),
    .next_value (field_next)
  );

  // Decode the session condition, button priority and the field being edited.
  always_comb begin
    in_set     = (state_q == SET_HH) || (state_q == SET_MM) || (state_q == SET_SS);
    inc_ev     = in_set && btn_inc && !btn_mode && !btn_cancel;
    tmo_expire = in_set && clk_1hz_tick && !btn_mode && !btn_inc && !btn_cancel &&
                 (tmo_q == TMO_LAST);
    field_val  = ss_q;
    field_max  = BCD_MS_MAX;
    case (state_q)
      SET_HH: begin
        field_val = hh_q;
        field_max = BCD_HH_MAX;
      end
      SET_MM: field_val = mm_q;
      default: ;
    endcase
  end

  // Next-state logic: cancel beats mode, and a timeout abort never loads.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (btn_mode && !btn_cancel) state_d = SET_HH;
      SET_HH: if (btn_cancel || tmo_expire) state_d = RUN;
              else if (btn_mode) state_d = SET_MM;
      SET_MM: if (btn_cancel || tmo_expire) state_d = RUN;
              else if (btn_mode) state_d = SET_SS;
      SET_SS: if (btn_cancel || tmo_expire) state_d = RUN;
              else if (btn_mode) state_d = LOAD;
      LOAD:   state_d = RUN;
      default: state_d = RUN;
    endcase
    in_set_d = (state_d == SET_HH) || (state_d == SET_MM) || (state_d == SET_SS);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Shadow time: snapshot on session entry, then BCD increments of the selected field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh_q <= 8'h00;
      mm_q <= 8'h00;
      ss_q <= 8'h00;
    end else if ((state_q == RUN) && (state_d == SET_HH)) begin
      hh_q <= cur_hh;
      mm_q <= cur_mm;
      ss_q <= cur_ss;
    end else if (inc_ev) begin
      case (state_q)
        SET_HH:  hh_q <= field_next;
        SET_MM:  mm_q <= field_next;
        default: ss_q <= field_next;
      endcase
    end
  end

  // Inactivity timer: counts 1 Hz ticks in a session, restarts on any mode/inc press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tmo_q <= 8'd0;
    else if (!in_set_d)               tmo_q <= 8'd0;
    else if (btn_mode || btn_inc)     tmo_q <= 8'd0;
    else if (clk_1hz_tick)            tmo_q <= tmo_q + 8'd1;
  end

  // Blink phase: restarts high on each newly entered field, low outside sessions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          blink_q <= 1'b0;
    else if (!in_set_d)               blink_q <= 1'b0;
    else if (state_d != state_q)      blink_q <= 1'b1;
    else if (!ACTIVE_BLINK)           blink_q <= 1'b1;
    else if (blink_tick)              blink_q <= ~blink_q;
  end

  // Outputs decode the registered state only, so buttons never reach them combinationally.
  always_comb begin
    case (state_q)
      SET_HH:  field_enc = FIELD_HH;
      SET_MM:  field_enc = FIELD_MM;
      SET_SS:  field_enc = FIELD_SS;
      default: field_enc = FIELD_NONE;
    endcase
    set_en    = (state_q != RUN);
    set_load  = (state_q == LOAD);
    field_sel = field_enc;
    set_hh    = hh_q;
    set_mm    = mm_q;
    set_ss    = ss_q;
    blink     = blink_q;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a table-driven full session plus
// hand-written sequences for wrap, priority, timeout and async reset.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1hz_tick, blink_tick, btn_mode, btn_inc, btn_cancel;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       set_en, set_load, blink;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [1:0] field_sel;

  int checks   = 0;
  int failures = 0;
  int loadCount = 0;

  typedef struct {
    string      name;
    logic       mode, inc, cancel;
    logic       en, load;
    logic [1:0] fs;
    logic       chkVals;
    logic [7:0] hh, mm, ss;
    logic       blk;
  } vec_t;

  vec_t vecs[14];

  clock_set_ctrl #(.TIMEOUT_S(3), .ACTIVE_BLINK(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_1hz_tick (clk_1hz_tick),
    .blink_tick   (blink_tick),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_cancel   (btn_cancel),
    .cur_hh       (cur_hh),
    .cur_mm       (cur_mm),
    .cur_ss       (cur_ss),
    .set_en       (set_en),
    .set_load     (set_load),
    .set_hh       (set_hh),
    .set_mm       (set_mm),
    .set_ss       (set_ss),
    .field_sel    (field_sel),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  // Count load strobes, sampled away from the active edge.
  always @(negedge clk) if (set_load === 1'b1) loadCount++;

  function automatic vec_t mkVec(string n, logic m, logic i, logic c, logic en, logic ld,
                                 logic [1:0] fs, logic cv, logic [7:0] hh, logic [7:0] mm,
                                 logic [7:0] ss, logic b);
    vec_t v;
    v.name = n; v.mode = m; v.inc = i; v.cancel = c; v.en = en; v.load = ld;
    v.fs = fs; v.chkVals = cv; v.hh = hh; v.mm = mm; v.ss = ss; v.blk = b;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one cycle of pulses, let the edge happen, and return #1 after it.
  task automatic applyStimulus(input logic m, input logic i, input logic c,
                               input logic t, input logic b);
    btn_mode = m; btn_inc = i; btn_cancel = c; clk_1hz_tick = t; blink_tick = b;
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_cancel = 1'b0; clk_1hz_tick = 1'b0; blink_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic checkRow(input vec_t v);
    checkOutput({v.name, ".en"},   {7'd0, set_en},    {7'd0, v.en});
    checkOutput({v.name, ".load"}, {7'd0, set_load},  {7'd0, v.load});
    checkOutput({v.name, ".fs"},   {6'd0, field_sel}, {6'd0, v.fs});
    checkOutput({v.name, ".blk"},  {7'd0, blink},     {7'd0, v.blk});
    if (v.chkVals) begin
      checkOutput({v.name, ".hh"}, set_hh, v.hh);
      checkOutput({v.name, ".mm"}, set_mm, v.mm);
      checkOutput({v.name, ".ss"}, set_ss, v.ss);
    end
  endtask

  initial begin
    int loadsBefore;
    rst = 1'b1;
    btn_mode = 0; btn_inc = 0; btn_cancel = 0; clk_1hz_tick = 0; blink_tick = 0;
    cur_hh = 8'h12; cur_mm = 8'h34; cur_ss = 8'h56;

    // Full session table: 12:34:56 -> 13:35:00, one load.
    vecs[0]  = mkVec("enter",  1, 0, 0, 1, 0, 2'd1, 1, 8'h12, 8'h34, 8'h56, 1);
    vecs[1]  = mkVec("incHH",  0, 1, 0, 1, 0, 2'd1, 1, 8'h13, 8'h34, 8'h56, 1);
    vecs[2]  = mkVec("toMM",   1, 0, 0, 1, 0, 2'd2, 1, 8'h13, 8'h34, 8'h56, 1);
    vecs[3]  = mkVec("incMM",  0, 1, 0, 1, 0, 2'd2, 1, 8'h13, 8'h35, 8'h56, 1);
    vecs[4]  = mkVec("toSS",   1, 0, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h56, 1);
    vecs[5]  = mkVec("incSS1", 0, 1, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h57, 1);
    vecs[6]  = mkVec("incSS2", 0, 1, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h58, 1);
    vecs[7]  = mkVec("incSS3", 0, 1, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h59, 1);
    vecs[8]  = mkVec("incSS4", 0, 1, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h00, 1);
    vecs[9]  = mkVec("hold",   0, 0, 0, 1, 0, 2'd3, 1, 8'h13, 8'h35, 8'h00, 1);
    vecs[10] = mkVec("load",   1, 0, 0, 1, 1, 2'd0, 1, 8'h13, 8'h35, 8'h00, 0);
    vecs[11] = mkVec("back",   0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0);
    vecs[12] = mkVec("runInc", 0, 1, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0);
    vecs[13] = mkVec("runIdle",0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.en",   {7'd0, set_en},    8'd0);
    checkOutput("rst.load", {7'd0, set_load},  8'd0);
    checkOutput("rst.fs",   {6'd0, field_sel}, 8'd0);
    checkOutput("rst.blk",  {7'd0, blink},     8'd0);
    checkOutput("rst.hh",   set_hh, 8'h00);
    checkOutput("rst.mm",   set_mm, 8'h00);
    checkOutput("rst.ss",   set_ss, 8'h00);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    loadsBefore = loadCount;
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vecs[r].mode, vecs[r].inc, vecs[r].cancel, 1'b0, 1'b0);
      checkRow(vecs[r]);
    end
    checkOutput("session.loads", 8'(loadCount - loadsBefore), 8'd1);

    // Wrap: hh 22->23->00, mm 59->00 leaving hh alone, ss 09->10, cancel from SET_SS.
    cur_hh = 8'h22; cur_mm = 8'h59; cur_ss = 8'h09;
    loadsBefore = loadCount;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wrap.hh0", set_hh, 8'h22);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap.hh23", set_hh, 8'h23);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap.hh00", set_hh, 8'h00);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap.mm00", set_mm, 8'h00);
    checkOutput("wrap.hhKeep", set_hh, 8'h00);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap.ss10", set_ss, 8'h10);
    checkOutput("wrap.mmKeep", set_mm, 8'h00);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wrap.cancelEn", {7'd0, set_en}, 8'd0);
    idle(2);
    checkOutput("wrap.noLoad", 8'(loadCount - loadsBefore), 8'd0);

    // Blink toggling, mode+inc priority, cancel from SET_MM.
    cur_hh = 8'h12; cur_mm = 8'h34; cur_ss = 8'h56;
    loadsBefore = loadCount;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("blk.entry", {7'd0, blink}, 8'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("blk.tog0", {7'd0, blink}, 8'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("blk.tog1", {7'd0, blink}, 8'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("prio.fs", {6'd0, field_sel}, 8'd2);
    checkOutput("prio.hh", set_hh, 8'h12);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("cancelMM.en", {7'd0, set_en}, 8'd0);
    checkOutput("cancelMM.fs", {6'd0, field_sel}, 8'd0);
    idle(2);
    checkOutput("cancelMM.noLoad", 8'(loadCount - loadsBefore), 8'd0);

    // Invalid BCD snapshot is cleared by the first increment.
    cur_hh = 8'h1A;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("inval.copy", set_hh, 8'h1A);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("inval.inc", set_hh, 8'h00);
    applyStimulus(0, 0, 1, 0, 0);
    cur_hh = 8'h12;

    // Timeout after 3 idle ticks in SET_SS.
    loadsBefore = loadCount;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("tmo.inSS", {6'd0, field_sel}, 8'd3);
    applyStimulus(0, 0, 0, 1, 0); idle(1);
    applyStimulus(0, 0, 0, 1, 0); idle(2);
    checkOutput("tmo.alive2", {7'd0, set_en}, 8'd1);
    applyStimulus(0, 0, 0, 1, 0); idle(2);
    checkOutput("tmo.expired", {7'd0, set_en}, 8'd0);
    checkOutput("tmo.noLoad", 8'(loadCount - loadsBefore), 8'd0);

    // Timeout restarted by btn_inc after 2 ticks.
    loadsBefore = loadCount;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0); idle(1);
    applyStimulus(0, 0, 0, 1, 0); idle(1);
    applyStimulus(0, 1, 0, 0, 0); idle(1);
    applyStimulus(0, 0, 0, 1, 0); idle(1);
    applyStimulus(0, 0, 0, 1, 0); idle(2);
    checkOutput("tmoR.alive", {7'd0, set_en}, 8'd1);
    applyStimulus(0, 0, 0, 1, 0); idle(2);
    checkOutput("tmoR.expired", {7'd0, set_en}, 8'd0);
    checkOutput("tmoR.noLoad", 8'(loadCount - loadsBefore), 8'd0);

    // Asynchronous reset during SET_SS.
    loadsBefore = loadCount;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.en",  {7'd0, set_en},    8'd0);
    checkOutput("arst.fs",  {6'd0, field_sel}, 8'd0);
    checkOutput("arst.blk", {7'd0, blink},     8'd0);
    checkOutput("arst.hh",  set_hh, 8'h00);
    checkOutput("arst.ss",  set_ss, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("arst.incIgn.en", {7'd0, set_en}, 8'd0);
    checkOutput("arst.incIgn.hh", set_hh, 8'h00);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("arst.new.fs", {6'd0, field_sel}, 8'd1);
    checkOutput("arst.new.hh", set_hh, 8'h12);
    checkOutput("arst.noLoad", 8'(loadCount - loadsBefore), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
